// File: rtl/vector_result_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_result_writer_pkg
// Description : Shared widths, FSM encodings and VL clamp for result writers.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_result_writer_pkg;

    localparam int VREG_ELEMS   = 64;
    localparam int VREG_ELEM_AW = 6;
    localparam int VL_W         = 7;
    localparam int DATA_W       = 64;

    localparam logic [1:0] WR_IDLE  = 2'd0;
    localparam logic [1:0] WR_WAIT  = 2'd1;
    localparam logic [1:0] WR_WRITE = 2'd2;

    // Illegal lengths above a full register behave as a full register.
    function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl);
        if (vl > VL_W'(VREG_ELEMS)) begin
            return VL_W'(VREG_ELEMS);
        end
        return vl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_result_writer_counter.sv
`default_nettype none
// ============================================================================
// Module      : vl_element_counter
// Description : Loadable element up-counter, terminal compare and saturation
//               against the latched vector length.
// Revision    : 1.0 - initial release
// ============================================================================
module vl_element_counter
    import vector_result_writer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_inc,
    input  logic [VL_W-1:0] i_limit,
    output logic [VL_W-1:0] o_count,
    output logic            o_last
);

    logic [VL_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != i_limit)) begin
            r_count <= r_count + VL_W'(1);
        end
    end

    assign o_count = r_count;
    // Asserted while the count sits on the final element index (limit - 1).
    assign o_last  = ((r_count + VL_W'(1)) == i_limit);

endmodule
`default_nettype wire

// File: rtl/vector_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : vector_result_writer
// Description : Write-back of a fixed-latency vector unit result stream into
//               destination register Vi, with chain count and busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_result_writer
    import vector_result_writer_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int ELEM_AW = VREG_ELEM_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [VL_W-1:0]    i_vl,
    input  logic [2:0]         i_i,
    input  logic [DATA_W-1:0]  i_result,
    output logic               o_we,
    output logic [2:0]         o_wreg,
    output logic [ELEM_AW-1:0] o_waddr,
    output logic [DATA_W-1:0]  o_wdata,
    output logic [VL_W-1:0]    o_elems_done,
    output logic               o_busy
);

    localparam logic [3:0] c_wait_load = 4'(LATENCY - 1);

    logic [1:0]         r_state;
    logic [VL_W-1:0]    r_vl;
    logic [2:0]         r_reg;
    logic [3:0]         r_wait;
    logic               r_we;
    logic [2:0]         r_wreg;
    logic [ELEM_AW-1:0] r_waddr;
    logic [DATA_W-1:0]  r_wdata;

    logic               w_accept;
    logic [VL_W-1:0]    w_vl_clamped;
    logic [VL_W-1:0]    w_elem_cnt;
    logic               w_elem_last;
    logic               w_done_last;
    logic               w_unused;

    assign w_vl_clamped = clamp_vl(i_vl);
    // The final o_we cycle still counts as busy, so a start there is dropped.
    assign w_accept     = i_start && (r_state == WR_IDLE) && !r_we;

    vl_element_counter u_elem_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_accept),
        .i_inc   (r_state == WR_WRITE),
        .i_limit (r_vl),
        .o_count (w_elem_cnt),
        .o_last  (w_elem_last)
    );

    // Counts completed writes: steps on the edge that closes each o_we cycle.
    vl_element_counter u_done_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_accept),
        .i_inc   (r_we),
        .i_limit (r_vl),
        .o_count (o_elems_done),
        .o_last  (w_done_last)
    );

    assign w_unused = &{1'b0, w_elem_cnt[VL_W-1:ELEM_AW], w_done_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WR_IDLE;
            r_vl    <= '0;
            r_reg   <= '0;
            r_wait  <= '0;
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                WR_IDLE: begin
                    if (w_accept) begin
                        r_vl   <= w_vl_clamped;
                        r_reg  <= i_i;
                        r_wait <= c_wait_load;
                        if (w_vl_clamped != '0) begin
                            r_state <= (LATENCY == 1) ? WR_WRITE : WR_WAIT;
                        end
                    end
                end
                WR_WAIT: begin
                    // Leave on the edge where the count reaches zero so that
                    // element 0 is captured exactly LATENCY edges after start.
                    r_wait <= r_wait - 4'd1;
                    if (r_wait == 4'd1) begin
                        r_state <= WR_WRITE;
                    end
                end
                WR_WRITE: begin
                    r_we    <= 1'b1;
                    r_wreg  <= r_reg;
                    r_waddr <= w_elem_cnt[ELEM_AW-1:0];
                    r_wdata <= i_result;
                    if (w_elem_last) begin
                        r_state <= WR_IDLE;
                    end
                end
                default: r_state <= WR_IDLE;
            endcase
        end
    end

    assign o_we    = r_we;
    assign o_wreg  = r_wreg;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;
    assign o_busy  = (r_state != WR_IDLE) || r_we;

endmodule
`default_nettype wire
